avr_fetch_q: RTL
================

Name: avr_fetch_q

Overview:
- Parametrised successor to the single-register fetch stage: a program-memory fetch unit with a DEPTH-entry prefetch queue, ready/valid hand-off to the decoder, and relative/absolute redirect with flush.
- Sits between synchronous program memory (1-cycle read latency) and the AVR decoder/ALU.
- Each queued word carries its PC so the decoder can compute relative branches.

Parameters:
- PC_W, 16, width of program counter and prog_addr (word address).
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.

Ports:
- CLK  in  1  clock, rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- prog_req  out  1  program memory read strobe.
- prog_addr  out  PC_W  program memory word address.
- prog_data  in  16  read data, valid the cycle after prog_req.
- instr  out  16  head-of-queue instruction word.
- instr_pc  out  PC_W  word address of instr.
- instr_valid  out  1  head entry is valid.
- instr_ready  in  1  decoder consumes head this cycle.
- redirect  in  1  flush and retarget fetch.
- redirect_rel  in  1  1: target = redirect_pc + 1 + redirect_tgt (signed); 0: target = redirect_tgt.
- redirect_pc  in  PC_W  PC of the redirecting instruction.
- redirect_tgt  in  PC_W  absolute target or signed offset.
- fill_level  out  clog2(DEPTH)+1  queued entries, excluding in-flight.
- instr_ext  out  16  second word of a 32-bit op (see Optional Feature).
- instr_is32  out  1  head is a 32-bit op (see Optional Feature).

Behaviour:
- Reset (RST_N low, asynchronous):
  - fetch PC fpc=0, queue empty, in-flight flag=0.
  - prog_req=0, prog_addr=0.
  - instr=16'h0000 (NOP), instr_pc=0, instr_valid=0, fill_level=0, instr_ext=0, instr_is32=0.
- First request after reset: the first rising edge after RST_N deasserts issues fetch of address 0. Data enters the queue one edge later. instr_valid rises 2 cycles after reset release.
- Issue rule:
  - prog_req=1 when fill_level + inflight + (pop ? -1 : 0) < DEPTH and redirect=0.
  - prog_addr=fpc. On issue, fpc <= fpc+1, wrapping modulo 2^PC_W (0xFFFF -> 0x0000 at PC_W=16).
- Return: cycle after an issue, {prog_data, issued PC} is pushed at the tail unless the request was killed by a redirect.
- Pop: when instr_valid && instr_ready, the head advances. Push and pop in the same cycle keep fill_level unchanged. A full queue with simultaneous pop accepts the push.
- Empty queue: instr_valid=0 and instr=16'h0000. The queue never bypasses memory data to the output; minimum latency from request to instr_valid is 2 cycles.
- Redirect (priority over push, pop and issue):
  - Queue cleared; any in-flight return that arrives next cycle is discarded.
  - fpc <= target (PC_W-bit add, wraps); prog_req=0 that cycle.
  - instr_valid=0 the following cycle. First target word is visible 2 cycles after the redirect edge.
- Redirect with instr_ready=1 in the same cycle: the pop is ignored, and the head is not reported as consumed.
- Redirect held for multiple cycles: each cycle re-flushes; the last target wins.
- Asynchronous reset mid-operation: immediate return to reset values; no pending request survives.
- prog_data is sampled only for non-killed requests; it may be X otherwise.

Optional Feature:
- Macro: FETCH_PAIR32_EN.
- With the macro defined:
  - Head opcodes JMP/CALL (1001010xxxxx11xx) and LDS/STS (100100xxxxxx0000) set instr_is32=1.
  - instr_valid for such a head asserts only when fill_level>=2; instr_ext = second entry.
  - A pop removes 2 entries.
- Without the macro:
  - instr_is32=0 and instr_ext=16'h0000 constantly.
  - Every pop removes one entry.

Test Plan:
- Reset, memory returns word = address: instr_valid rises cycle 2 with instr=0x0000, instr_pc=0. With instr_ready=1 held, instr_pc reads 0,1,2,3… one per cycle.
- instr_ready=0 for 10 cycles: fill_level saturates at 4 and prog_req drops. After instr_ready=1, words 0–3 drain in order with no loss or duplicate.
- Absolute redirect to 0x0100 while queue holds 3 entries: next cycle fill_level=0. Two cycles later instr_pc=0x0100, and the in-flight word is never seen.
- Relative redirect with redirect_pc=0x0010, redirect_tgt=0xFFFE (-2): next instr_pc=0x000F. redirect_tgt=0x0005 from redirect_pc=0xFFFC gives 0x0002 (wrap).
- Assert RST_N low mid-stream while queue is full: outputs return to reset values immediately, without a clock edge.
- FETCH_PAIR32_EN, memory word 0=0x940C (JMP), word 1=0x1234: instr_is32=1 and instr_ext=0x1234 in the same cycle. A single pop advances instr_pc to 2.

Source files
------------

// File: rtl/avr_fetch_q_if.sv
// ---------------------------------------------------------------------------
// avr_fetch_q_if
// Bundles the program-memory read bus, the decoder hand-off and the redirect
// controls of the avr_fetch_q prefetch unit.
//
// Parameters must match the avr_fetch_q instance that uses the interface:
//   PC_W   program counter / word address width
//   DEPTH  prefetch queue entries (power of two, >= 2)
//
// Modports:
//   master : fetch unit side (drives prog_req/prog_addr and the instr_* outputs)
//   slave  : environment side (program memory, decoder, branch unit)
//
// Handshake: a head entry is transferred to the decoder on every rising CLK
// edge where instr_valid && instr_ready are both 1 and redirect is 0.
// instr_valid never depends on instr_ready. prog_data is consumed on the
// edge one cycle after the edge that registered prog_req=1.
// ---------------------------------------------------------------------------
interface avr_fetch_q_if #(
   parameter int PC_W  = 16,
   parameter int DEPTH = 4
);
   localparam int FL_W = $clog2(DEPTH) + 1;

   // program memory bus
   logic            prog_req;
   logic [PC_W-1:0] prog_addr;
   logic [15:0]     prog_data;

   // decoder hand-off
   logic [15:0]     instr;
   logic [PC_W-1:0] instr_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic [FL_W-1:0] fill_level;
   logic [15:0]     instr_ext;
   logic            instr_is32;

   // redirect
   logic            redirect;
   logic            redirect_rel;
   logic [PC_W-1:0] redirect_pc;
   logic [PC_W-1:0] redirect_tgt;

   modport master (
      output prog_req, prog_addr,
      input  prog_data,
      output instr, instr_pc, instr_valid, fill_level, instr_ext, instr_is32,
      input  instr_ready,
      input  redirect, redirect_rel, redirect_pc, redirect_tgt
   );

   modport slave (
      input  prog_req, prog_addr,
      output prog_data,
      input  instr, instr_pc, instr_valid, fill_level, instr_ext, instr_is32,
      output instr_ready,
      output redirect, redirect_rel, redirect_pc, redirect_tgt
   );
endinterface

// File: rtl/avr_fetch_q.sv
// ---------------------------------------------------------------------------
// avr_fetch_q
// AVR program-memory fetch unit with a DEPTH-entry prefetch queue. Each
// queued entry holds the instruction word and its word address so the
// decoder can resolve relative branches. A redirect flushes the queue,
// kills the in-flight read and retargets the fetch PC.
//
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    avr_fetch_q_if.master (memory bus, decoder hand-off, redirect)
//
// Optional build macro: FETCH_PAIR32_EN
//   Defined  : JMP/CALL and LDS/STS heads are reported as 32-bit ops; such a
//              head is valid only once its second word is queued, the second
//              word appears on instr_ext and a pop removes both entries.
//   Undefined: instr_is32=0, instr_ext=0, every pop removes one entry.
// ---------------------------------------------------------------------------
module avr_fetch_q #(
   parameter int PC_W  = 16,
   parameter int DEPTH = 4
) (
   input  logic           CLK,
   input  logic           RST_N,
   avr_fetch_q_if.master  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int FL_W  = PTR_W + 1;

   typedef struct packed {
      logic [15:0]     word;
      logic [PC_W-1:0] pc;
   } entry_t;

   entry_t           q_mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [FL_W-1:0]  count;
   logic [PC_W-1:0]  fpc;
   logic             inflight;
   logic [PC_W-1:0]  inflight_pc;

   entry_t           head;
   logic             non_empty;
   logic             head_ok;
   logic             head_is32;
   logic [FL_W-1:0]  pop_n;
   logic [FL_W-1:0]  pop_cnt;
   logic             pop;
   logic             push;
   logic             issue;
   logic [PC_W-1:0]  target;
   logic [15:0]      ext_word;
   int               occ;

   // ------------------------------------------------------------------------
   // Head decode and hand-off control
   // ------------------------------------------------------------------------
   always_comb begin
      head      = q_mem[rd_ptr];
      non_empty = (count != '0);
      head_is32 = 1'b0;
      ext_word  = 16'h0000;
      pop_n     = FL_W'(1);
      head_ok   = non_empty;
`ifdef FETCH_PAIR32_EN
      // JMP/CALL: 1001_010x_xxxx_11xx, LDS/STS: 1001_00xx_xxxx_0000
      head_is32 = non_empty &&
                  ((head.word[15:9] == 7'b1001010 && head.word[3:2] == 2'b11) ||
                   (head.word[15:10] == 6'b100100 && head.word[3:0] == 4'b0000));
      if (count >= FL_W'(2))
         ext_word = q_mem[rd_ptr + PTR_W'(1)].word;
      if (head_is32) begin
         pop_n   = FL_W'(2);
         head_ok = (count >= FL_W'(2));
      end
`endif

      // Redirect wins over pop, push and issue.
      pop     = head_ok && bus.instr_ready && !bus.redirect;
      pop_cnt = pop ? pop_n : '0;
      push    = inflight && !bus.redirect;

      // Room check counts the word still in flight and frees the slots being
      // popped this cycle, so a full queue with a pop can keep streaming.
      occ   = int'(count) + int'(inflight) - int'(pop_cnt);
      // Gating with RST_N keeps the strobe low while reset is held.
      issue = RST_N && !bus.redirect && (occ < DEPTH);

      if (bus.redirect_rel)
         target = bus.redirect_pc + PC_W'(1) + bus.redirect_tgt;
      else
         target = bus.redirect_tgt;
   end

   // ------------------------------------------------------------------------
   // Outputs: zeros whenever the queue is empty
   // ------------------------------------------------------------------------
   assign bus.prog_req    = issue;
   assign bus.prog_addr   = fpc;
   assign bus.instr       = non_empty ? head.word : 16'h0000;
   assign bus.instr_pc    = non_empty ? head.pc : '0;
   assign bus.instr_valid = head_ok;
   assign bus.fill_level  = count;
   assign bus.instr_ext   = ext_word;
   assign bus.instr_is32  = head_is32;

   // ------------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fpc         <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (bus.redirect) begin
         // Clearing inflight discards the word returning this cycle; no new
         // request was issued, so nothing returns next cycle either.
         fpc      <= target;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            fpc         <= fpc + PC_W'(1);
            inflight_pc <= fpc;
         end
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + pop_cnt[PTR_W-1:0];
         count <= count + FL_W'(push) - pop_cnt;
      end
   end

   // Queue storage needs no reset: entries are only read while counted.
   always_ff @(posedge CLK) begin
      if (RST_N && push)
         q_mem[wr_ptr] <= '{word: bus.prog_data, pc: inflight_pc};
   end
endmodule
